// File: rtl/cond_issue_queue_pkg.sv
// Shared constants for the conditional issue queue: ARM-style condition
// codes and the bit positions of N/Z/C/V inside the 4-bit flags bus.
package cond_issue_queue_pkg;

  localparam int COND_W = 4;

  typedef enum logic [COND_W-1:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
    CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
    CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_issue_queue_if.sv
// Upstream/downstream valid-ready handshake bundle for the issue queue.
interface cond_issue_queue_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/cond_issue_queue_cond_eval.sv
// Combinational condition-code check of a 4-bit cond field against NZCV.
module cond_eval
  import cond_issue_queue_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  logic [3:0]        flags,
  output logic              pass
);
  logic w_n, w_z, w_c, w_v;

  assign w_n = flags[FLAG_N];
  assign w_z = flags[FLAG_Z];
  assign w_c = flags[FLAG_C];
  assign w_v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      CC_EQ: pass = w_z;
      CC_NE: pass = !w_z;
      CC_CS: pass = w_c;
      CC_CC: pass = !w_c;
      CC_MI: pass = w_n;
      CC_PL: pass = !w_n;
      CC_VS: pass = w_v;
      CC_VC: pass = !w_v;
      CC_HI: pass = w_c && !w_z;
      CC_LS: pass = !w_c || w_z;
      CC_GE: pass = (w_n == w_v);
      CC_LT: pass = (w_n != w_v);
      CC_GT: pass = !w_z && (w_n == w_v);
      CC_LE: pass = w_z || (w_n != w_v);
      CC_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/cond_issue_queue.sv
// In-order issue queue: head word issues to a single output register when its
// condition passes against the current flags, or is dropped and counted.
module cond_issue_queue
  import cond_issue_queue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  cond_issue_queue_if.slave        bus,
  input  logic [3:0]               flags,
  input  logic                     flags_valid,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         squash_count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wptr, r_rptr;
  logic              r_live;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CNT_W-1:0]  r_squash;

  logic              w_empty, w_full, w_in_ready, w_push;
  logic              w_out_free, w_eval, w_pass, w_issue, w_squash;
  logic [DATA_W-1:0] w_head;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // r_live keeps in_ready low through reset and for the edge it is released on
  assign w_in_ready = r_live && !w_full;
  assign w_push     = bus.in_valid && w_in_ready;

  assign w_head     = r_mem[r_rptr[AW-1:0]];
  assign w_out_free = !r_out_valid || bus.out_ready;
  assign w_eval     = !w_empty && flags_valid && w_out_free;
  assign w_issue    = w_eval && w_pass;
  assign w_squash   = w_eval && !w_pass;

  cond_eval u_cond (
    .cond  (w_head[DATA_W-1 -: COND_W]),
    .flags (flags),
    .pass  (w_pass)
  );

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_live      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_squash    <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_eval) r_rptr <= r_rptr + 1'b1;
      if (w_issue) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_head;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_squash && (r_squash != '1)) r_squash <= r_squash + 1'b1;
    end
  end

  assign occupancy     = r_wptr - r_rptr;
  assign squash_count  = r_squash;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
endmodule

// File: tb/tb_cond_issue_queue.sv
// Directed bench for cond_issue_queue: ordering, backpressure, flag stalls,
// full condition table, counter saturation and asynchronous reset.
module tb_cond_issue_queue;
  localparam int DW = 32;

  logic clk;
  logic rst;

  cond_issue_queue_if #(.DATA_W(DW)) bus ();
  logic [3:0]  flags;
  logic        flags_valid;
  logic [2:0]  occ;
  logic [15:0] sq;

  cond_issue_queue_if #(.DATA_W(DW)) sbus ();
  logic [3:0]  sflags;
  logic        sflags_valid;
  logic [2:0]  socc;
  logic [3:0]  ssq;

  cond_issue_queue #(.DATA_W(DW), .DEPTH(4), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .flags        (flags),
    .flags_valid  (flags_valid),
    .occupancy    (occ),
    .squash_count (sq)
  );

  cond_issue_queue #(.DATA_W(DW), .DEPTH(4), .CNT_W(4)) u_sat (
    .clk          (clk),
    .rst          (rst),
    .bus          (sbus),
    .flags        (sflags),
    .flags_valid  (sflags_valid),
    .occupancy    (socc),
    .squash_count (ssq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;
  logic [DW-1:0] log_q [$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Logs the transfer about to happen on the coming edge, then steps to just after it.
  task automatic cyc();
    if (bus.out_valid && bus.out_ready) log_q.push_back(bus.out_data);
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    int k;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (k = 0; k < 20 && !bus.in_ready; k++) cyc();
    if (k == 20) chk("push_timeout", 1, 0);
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 40; k++) begin
      if (occ == 0 && !bus.out_valid) break;
      cyc();
    end
    if (k == 40) chk("drain_timeout", 1, 0);
  endtask

  function automatic bit exp_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, b;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cf;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cf && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: b = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? !b : b;
  endfunction

  initial begin
    logic [DW-1:0] exp_q [$];
    logic [15:0]   sq0;
    logic [DW-1:0] w;
    int            nfail_exp, n;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    sbus.in_valid = 1'b0; sbus.in_data = '0; sbus.out_ready = 1'b0;
    flags = 4'h0; flags_valid = 1'b0; sflags = 4'h0; sflags_valid = 1'b0;

    #2;
    chk("rst_occ", occ, 0);
    chk("rst_ovalid", bus.out_valid, 0);
    chk("rst_odata", bus.out_data, 0);
    chk("rst_squash", sq, 0);
    chk("rst_iready", bus.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("iready_before_edge", bus.in_ready, 0);
    cyc();
    chk("iready_after_edge", bus.in_ready, 1);

    // EQ issues, NE squashes with Z set
    flags = 4'b0100; flags_valid = 1'b1; bus.out_ready = 1'b1;
    push(32'h0000_0011);
    push(32'h1000_0022);
    chk("eq_ovalid", bus.out_valid, 1);
    chk("eq_odata", bus.out_data, 32'h0000_0011);
    cyc();
    chk("ne_squash", sq, 1);
    chk("ne_ovalid", bus.out_valid, 0);
    chk("ne_occ", occ, 0);
    chk("eqne_log_n", log_q.size(), 1);
    if (log_q.size() > 0) chk("eqne_log0", log_q[0], 32'h0000_0011);

    // backpressure: 5 AL words, output blocked
    log_q.delete();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hE000_0000 | i;
      cyc();
    end
    bus.in_data = 32'hE000_0006;
    cyc();
    bus.in_valid = 1'b0;
    chk("bp_occ", occ, 4);
    chk("bp_iready", bus.in_ready, 0);
    chk("bp_ovalid", bus.out_valid, 1);
    chk("bp_odata", bus.out_data, 32'hE000_0001);
    cyc();
    chk("bp_odata_hold", bus.out_data, 32'hE000_0001);
    bus.out_ready = 1'b1;
    drain();
    chk("bp_log_n", log_q.size(), 5);
    for (int i = 0; i < log_q.size() && i < 5; i++)
      chk("bp_order", log_q[i], 32'hE000_0001 + i);
    chk("bp_squash", sq, 1);

    // flags not valid: stall, then resume
    log_q.delete();
    sq0 = sq;
    flags_valid = 1'b0;
    push(32'hE000_00A1);
    push(32'hF000_00A2);
    push(32'hE000_00A3);
    cyc(); cyc();
    chk("stall_ovalid", bus.out_valid, 0);
    chk("stall_squash", sq, sq0);
    chk("stall_occ", occ, 3);
    flags_valid = 1'b1;
    cyc();
    chk("resume_ovalid", bus.out_valid, 1);
    chk("resume_odata", bus.out_data, 32'hE000_00A1);
    drain();
    chk("resume_log_n", log_q.size(), 2);
    if (log_q.size() == 2) chk("resume_log1", log_q[1], 32'hE000_00A3);
    chk("resume_squash", sq, sq0 + 16'd1);

    // full condition x flags table
    for (int f = 0; f < 16; f++) begin
      log_q.delete();
      exp_q.delete();
      sq0 = sq;
      nfail_exp = 0;
      flags = 4'(f);
      for (int c = 0; c < 16; c++) begin
        w = {4'(c), 20'h0, 4'(f), 4'(c)};
        if (exp_pass(4'(c), 4'(f))) exp_q.push_back(w);
        else nfail_exp++;
        push(w);
      end
      drain();
      chk("tbl_issued_n", log_q.size(), exp_q.size());
      for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
        chk("tbl_issued", log_q[i], exp_q[i]);
      chk("tbl_squash", sq, sq0 + 16'(nfail_exp));
    end

    // squash counter saturation on a 4-bit counter
    sflags_valid = 1'b1;
    sbus.out_ready = 1'b1;
    sbus.in_valid = 1'b1;
    sbus.in_data = 32'hF000_0000;
    n = 0;
    for (int k = 0; k < 200 && n < 19; k++) begin
      if (sbus.in_ready) n++;
      cyc();
    end
    sbus.in_valid = 1'b0;
    cyc(); cyc(); cyc();
    chk("sat_pushed", n, 19);
    chk("sat_count", ssq, 4'hF);
    chk("sat_ovalid", sbus.out_valid, 0);
    sbus.in_valid = 1'b1;
    cyc(); cyc();
    sbus.in_valid = 1'b0;
    cyc(); cyc();
    chk("sat_hold", ssq, 4'hF);

    // asynchronous reset mid-stream
    log_q.delete();
    bus.out_ready = 1'b0;
    push(32'hE000_00B1);
    push(32'hE000_00B2);
    push(32'hE000_00B3);
    push(32'hE000_00B4);
    chk("prerst_occ", occ, 3);
    chk("prerst_ovalid", bus.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_occ", occ, 0);
    chk("arst_ovalid", bus.out_valid, 0);
    chk("arst_odata", bus.out_data, 0);
    chk("arst_squash", sq, 0);
    chk("arst_iready", bus.in_ready, 0);
    #1 rst = 1'b0;
    cyc();
    chk("postrst_iready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    push(32'hE000_00F1);
    cyc();
    chk("postrst_ovalid", bus.out_valid, 1);
    chk("postrst_odata", bus.out_data, 32'hE000_00F1);
    cyc();
    chk("postrst_log_n", log_q.size(), 1);
    chk("postrst_occ", occ, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
